// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared trace record type and constants
package trace_pkg;

  localparam int TRACE_XLEN = 32;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] instruction;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [TRACE_XLEN-1:0] rd_value;
    logic [11:0]           imm;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// rtl/trace_fifo_mem.sv - trace record storage, one write port, async read port
module trace_fifo_mem
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_rec_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trace_rec_t    rdata_o
);

  trace_rec_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through trace buffer with overflow counter
// Define TRACE_NOP_FILTER_EN to discard canonical NOP records at the input.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = TRACE_XLEN,
  parameter int OVF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_instruction,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [XLEN-1:0]          in_rd_value,
  input  logic [11:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output trace_rec_t               out_rec,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [OVF_W-1:0]         overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic             accept, push, pop, drop;
  trace_rec_t       wr_rec;

`ifdef TRACE_NOP_FILTER_EN
  assign accept = in_valid && (in_instruction != NOP_INSN);
`else
  assign accept = in_valid;
`endif

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push      = accept && (!full || pop);
  assign drop      = accept && full && !pop;

  assign wr_rec = '{instruction: in_instruction, rd: in_rd, rs1: in_rs1,
                    rs2: in_rs2, rd_value: in_rd_value, imm: in_imm};

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    ovf_d = ovf_q;
    if (drop && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  trace_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_rec)
  );

  assign count        = count_q;
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_trace_fifo.sv
// tb/tb_trace_fifo.sv - randomized and directed bench for trace_fifo against a queue model
module tb_trace_fifo;
  import trace_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instruction = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_rd_value = '0;
  logic [11:0] in_imm = '0;
  logic        out_valid, out_ready = 1'b0;
  trace_rec_t  out_rec;
  logic [4:0]  count;
  logic        full, empty;
  logic [15:0] overflow_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  trace_fifo #(.DEPTH(DEPTH), .XLEN(32), .OVF_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instruction(in_instruction),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd_value(in_rd_value),
    .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .count(count), .full(full), .empty(empty), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of records plus a saturating drop counter.
  trace_rec_t mq[$];
  int         m_ovf = 0;
  bit         armed = 0;

  function automatic bit model_accept(input logic v, input logic [31:0] insn);
`ifdef TRACE_NOP_FILTER_EN
    return v && (insn != 32'h0000_0013);
`else
    return v;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0;
      armed = 1;
    end else if (armed) begin
      bit was_full, do_pop;
      trace_rec_t r;
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() > 0) && out_ready;
      r = '{instruction: in_instruction, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
            rd_value: in_rd_value, imm: in_imm};
      if (do_pop) void'(mq.pop_front());
      if (model_accept(in_valid, in_instruction)) begin
        if (was_full && !do_pop) begin
          if (m_ovf < 65535) m_ovf++;
        end else begin
          mq.push_back(r);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      check("count", count, mq.size());
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("out_valid", out_valid, mq.size() > 0);
      check("overflow_cnt", overflow_cnt, m_ovf);
      if (mq.size() > 0) check("out_rec", out_rec, mq[0]);
    end
  end

  // Apply inputs for the next rising edge, then move to just after that edge.
  task automatic step(input logic v, input logic [31:0] insn, input logic rdy);
    in_valid       = v;
    in_instruction = insn;
    in_rd          = 5'($urandom);
    in_rs1         = 5'($urandom);
    in_rs2         = 5'($urandom);
    in_rd_value    = $urandom;
    in_imm         = 12'($urandom);
    out_ready      = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Idle after reset
    step(1'b0, 32'h0, 1'b0);
    check("t1_out_valid", out_valid, 0);
    check("t1_empty", empty, 1);
    check("t1_count", count, 0);
    check("t1_ovf", overflow_cnt, 0);

    // Two records, sink stalled
    step(1'b1, 32'h0050_0093, 1'b0);
    step(1'b1, 32'h00A0_0113, 1'b0);
    check("t2_count", count, 2);
    check("t2_head", out_rec.instruction, 32'h0050_0093);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("t2_head_steady", out_rec.instruction, 32'h0050_0093);
    check("t2_count_steady", count, 2);

    // Overfill by two, then drain in order
    do_reset();
    for (int i = 1; i <= 18; i++) step(1'b1, 32'(i), 1'b0);
    check("t3_full", full, 1);
    check("t3_count", count, 16);
    check("t3_ovf", overflow_cnt, 2);
    for (int i = 1; i <= 16; i++) begin
      check("t3_drain", out_rec.instruction, 32'(i));
      step(1'b0, 32'h0, 1'b1);
    end
    check("t3_empty", empty, 1);

    // Full with simultaneous push and pop across pointer wrap
    for (int i = 0; i < 16; i++) step(1'b1, 32'(100 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'(200 + i), 1'b1);
      check("t4_count", count, 16);
      check("t4_ovf", overflow_cnt, 2);
    end
    for (int j = 0; j < 16; j++) begin
      check("t4_order", out_rec.instruction, (j < 11) ? 32'(105 + j) : 32'(200 + j - 11));
      step(1'b0, 32'h0, 1'b1);
    end

    // NOP record
    step(1'b1, 32'h0000_0013, 1'b0);
`ifdef TRACE_NOP_FILTER_EN
    check("t5_nop_count", count, 0);
`else
    check("t5_nop_count", count, 1);
`endif

    // Reset with seven records held
    for (int i = 0; i < 7; i++) step(1'b1, 32'(300 + i), 1'b0);
    check("t6_pre_count_ge7", count >= 7, 1);
    do_reset();
    check("t6_count", count, 0);
    check("t6_out_valid", out_valid, 0);
    check("t6_ovf", overflow_cnt, 0);

    // Randomized traffic with varying sink pressure
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] insn;
      int bias;
      bias = (i / 500) % 3;
      insn = ($urandom_range(0, 7) == 0) ? 32'h0000_0013 : $urandom;
      if ($urandom_range(0, 399) == 0) rst = 1'b1;
      step($urandom_range(0, 9) < 7,
           insn,
           (bias == 0) ? ($urandom_range(0, 9) < 2) :
           (bias == 1) ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 9) < 9));
      rst = 1'b0;
    end

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
